// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with private HI/LO; divider built only when MDU_DIV_EN is defined
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    // Multiply: {partial product, remaining multiplier}. Divide: {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    // Multiplicand magnitude for multiplies, divisor magnitude for divides.
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic                 neg1_q, neg1_d;
    logic                 neg2_q, neg2_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
`ifdef MDU_DIV_EN
    logic                 div_q, div_d;
    // Raw dividend kept for the divide-by-zero result (HI = original rs).
    logic [WIDTH-1:0]     in1_raw_q, in1_raw_d;
`endif

    logic                 accept;
    logic                 is_signed;
    logic                 in1_neg;
    logic                 in2_neg;
    logic [WIDTH-1:0]     in1_mag;
    logic [WIDTH-1:0]     in2_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_step;
    logic [2*WIDTH-1:0]   product;

    assign is_signed = ~op[0];
    assign in1_neg   = is_signed & in1[WIDTH-1];
    assign in2_neg   = is_signed & in2[WIDTH-1];
    assign in1_mag   = in1_neg ? -in1 : in1;
    assign in2_mag   = in2_neg ? -in2 : in2;

`ifdef MDU_DIV_EN
    assign accept = start && (state_q == S_IDLE);
`else
    // Without the divider, divide opcodes are simply not accepted.
    assign accept = start && (state_q == S_IDLE) && !op[1];
`endif

    // One radix-2 shift-add step; the carry out of the add becomes the new MSB.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + {1'b0, (acc_q[0] ? mcand_q : {WIDTH{1'b0}})};
    assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};
    assign product  = (neg1_q ^ neg2_q) ? -acc_q : acc_q;

`ifdef MDU_DIV_EN
    logic [WIDTH:0]       div_shift;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   div_step;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, mcand_q};
    assign div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, mcand_q}) : div_shift[WIDTH-1:0];
    assign div_step  = {div_rem, acc_q[WIDTH-2:0], div_ge};

    // Quotient negated on sign mismatch; remainder follows the dividend's sign.
    assign quot_fix  = (neg1_q ^ neg2_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix   = neg1_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif

    // Sequencer: IDLE -> CALC on accepted start, CALC -> FIX after WIDTH steps, FIX -> IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_CALC;
                    cnt_d   = '0;
                end
            end
            S_CALC: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Datapath: operand capture, per-cycle iteration, sign fix-up and HI/LO writes.
    always_comb begin
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        neg1_d    = neg1_q;
        neg2_d    = neg2_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = (state_q == S_FIX);
`ifdef MDU_DIV_EN
        div_d     = div_q;
        in1_raw_d = in1_raw_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    neg1_d = in1_neg;
                    neg2_d = in2_neg;
`ifdef MDU_DIV_EN
                    div_d     = op[1];
                    in1_raw_d = in1;
                    if (op[1]) begin
                        acc_d   = {{WIDTH{1'b0}}, in1_mag};
                        mcand_d = in2_mag;
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, in2_mag};
                        mcand_d = in1_mag;
                    end
`else
                    acc_d   = {{WIDTH{1'b0}}, in2_mag};
                    mcand_d = in1_mag;
`endif
                end else begin
                    // A move coinciding with an accepted start is dropped.
                    if (mthi) begin
                        hi_d = wdata;
                    end
                    if (mtlo) begin
                        lo_d = wdata;
                    end
                end
            end
            S_CALC: begin
`ifdef MDU_DIV_EN
                acc_d = div_q ? div_step : mul_step;
`else
                acc_d = mul_step;
`endif
            end
            S_FIX: begin
`ifdef MDU_DIV_EN
                if (div_q) begin
                    if (mcand_q == '0) begin
                        hi_d = in1_raw_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end
                end else begin
                    hi_d = product[2*WIDTH-1:WIDTH];
                    lo_d = product[WIDTH-1:0];
                end
`else
                hi_d = product[2*WIDTH-1:WIDTH];
                lo_d = product[WIDTH-1:0];
`endif
            end
            default: begin
            end
        endcase
    end

    // State registers; reset discards any operation in flight and clears HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            neg1_q    <= 1'b0;
            neg2_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
`ifdef MDU_DIV_EN
            div_q     <= 1'b0;
            in1_raw_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            neg1_q    <= neg1_d;
            neg2_q    <= neg2_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
`ifdef MDU_DIV_EN
            div_q     <= div_d;
            in1_raw_q <= in1_raw_d;
`endif
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit in the execute stage, alongside the ALU. It takes the same two register-file operands the ALU receives (rs as `in1`, rt as `in2`) and executes MULT, MULTU, DIV and DIVU over multiple cycles into private HI/LO registers. It also implements MTHI and MTLO. HI/LO feed the writeback mux for MFHI/MFLO, and `busy` is used by the control unit to stall dependent instructions.

## Interface
Parameters:
- `WIDTH`, 32, operand width; also the number of iteration cycles.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  launch the operation selected by `op`; honoured only when idle.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `in1`  in  WIDTH  multiplicand / dividend (rs).
- `in2`  in  WIDTH  multiplier / divisor (rt).
- `mthi`  in  1  write `wdata` into HI.
- `mtlo`  in  1  write `wdata` into LO.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result.
- `hi`  out  WIDTH  HI register (remainder / product upper half).
- `lo`  out  WIDTH  LO register (quotient / product lower half).

## Operation
- States:
  - IDLE.
  - CALC: WIDTH iterations, counter 0..WIDTH-1.
  - FIX: sign correction and HI/LO write.
- Transitions:
  - IDLE→CALC on `start`.
  - CALC→FIX when the counter reaches WIDTH-1.
  - FIX→IDLE unconditionally.
- Operand capture:
  - On accepted `start`, latch `op`, sign flags, and magnitudes.
  - Signed ops use absolute values; unsigned ops use raw values.
  - Later changes on `in1`/`in2` have no effect.
- Multiply:
  - Radix-2 shift-add over a 2·WIDTH accumulator.
  - In FIX, negate the product if the operand signs differ (signed only).
  - `hi` = upper half, `lo` = lower half.
- Divide:
  - Restoring division, one quotient bit per CALC cycle.
  - In FIX, negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - `lo` = quotient, `hi` = remainder.
- Divide by zero (DIV or DIVU):
  - `hi` = original `in1`, `lo` = all ones.
  - Full latency; `done` still pulses.
- Signed DIV of most-negative by -1: `lo` = 0x80000000, `hi` = 0 (no trap).
- `busy` = (state != IDLE).
- `done` is registered and high only in the cycle after FIX.
- `start` while busy: ignored; the current operation is unaffected.
- `mthi`/`mtlo` while idle: update the register at the next edge.
- `mthi`/`mtlo` while busy: ignored.
- `start` and `mthi`/`mtlo` in the same idle cycle: `start` wins, the move is dropped.
- `mthi` and `mtlo` together: both registers are written.

## Timing
- `start` sampled high at the end of cycle T.
  - `busy` is high in cycles T+1 … T+WIDTH+1.
  - CALC occupies T+1 … T+WIDTH; FIX occupies T+WIDTH+1.
  - `hi`/`lo` are updated and `done`=1 in cycle T+WIDTH+2. For WIDTH=32, the result appears 34 cycles after the `start` cycle.
- A new `start` can be accepted in cycle T+WIDTH+2, the same cycle as `done`.
- MTHI/MTLO latency: 1 cycle.
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, counter 0.
- Reset mid-operation:
  - The operation is discarded and no `done` is produced.
  - HI/LO go to 0.

## Configuration
- `MDU_DIV_EN` defined:
  - Full behaviour as above.
- `MDU_DIV_EN` undefined:
  - The divider datapath is removed.
  - `start` with `op[1]`=1 is ignored: state stays IDLE, no `busy`, no `done`, HI/LO unchanged.
  - Multiply, MTHI and MTLO are unchanged.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, `start` in cycle T → `busy` for cycles T+1..T+33; `done` in T+34 with `hi`=0xFFFFFFFE, `lo`=0x00000001.
- MULT -3 × 7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- Divides:
  - DIV -7 ÷ 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIVU 7 ÷ 0 → `hi`=7, `lo`=0xFFFFFFFF, `done` at T+34.
  - DIV 0x80000000 ÷ 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Second `start` (MULTU 2×2) at T+5 during MULTU 3×3 → single `done` at T+34 with `lo`=9.
- Reset at T+10 of a DIVU → `busy`=0 and `hi`=`lo`=0 at T+11, no `done`.
- `mthi` with `wdata`=0x12345678 while idle → `hi`=0x12345678 next cycle.
- `mtlo` asserted together with `start` MULTU 1×1 → `lo`=1 at `done`, never equal to `wdata`.
- Build without `MDU_DIV_EN`, issue DIVU → `busy` never asserts, no `done`.
